enigma_decoder: RTL

- Receive side of the Enigma nibble code path: accepts 10-bit code words from the 4-to-10 breadboard encoder, validates them and recovers the 4-bit plaintext nibble.
- Removes a stepping rotor offset (Enigma-style) and delivers the nibble through a valid/ready output register.
- Sits between the code-word link and the downstream nibble consumer.
- Counts invalid code words for link diagnostics.

---
 rtl/enigma_pkg.sv | 16 +
 rtl/enigma_code_lookup.sv | 22 ++
 rtl/enigma_decoder.sv | 69 ++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared constants for the Enigma nibble code path: word widths and the
// 16-entry code table used by both the encoder and the decoder.
package enigma_pkg;

    localparam int unsigned CODE_W = 10;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned N_CODES = 16;

    localparam logic [CODE_W-1:0] CODE_TABLE [N_CODES] = '{
        10'h164, 10'h1BA, 10'h05D, 10'h0CF,
        10'h0BB, 10'h1CD, 10'h237, 10'h3A2,
        10'h29D, 10'h097, 10'h355, 10'h378,
        10'h31B, 10'h2C9, 10'h199, 10'h1F6
    };

endpackage

// File: rtl/enigma_code_lookup.sv
// Combinational reverse lookup: maps a 10-bit code word to its table index.
// hit is low for any of the 1008 values not in the table.
module enigma_code_lookup
    import enigma_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [NIB_W-1:0]  idx,
    output logic              hit
);

    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_CODES; i++) begin
            if (code == CODE_TABLE[i]) begin
                idx = i[NIB_W-1:0];
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enigma_decoder.sv
// Enigma receive path: validates code words, removes the stepping rotor
// offset and presents the nibble through a valid/ready output register.
module enigma_decoder
    import enigma_pkg::*;
#(
    parameter logic [NIB_W-1:0] ROTOR_INIT = 4'd0,
    parameter logic [NIB_W-1:0] ROTOR_STEP = 4'd1,
    parameter int unsigned      ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CODE_W-1:0]    code,
    input  logic                 code_valid,
    output logic                 code_ready,
    input  logic                 rotor_load,
    input  logic [NIB_W-1:0]     rotor_val,
    output logic [NIB_W-1:0]     nib,
    output logic                 nib_err,
    output logic                 nib_valid,
    input  logic                 nib_ready,
    output logic [NIB_W-1:0]     rotor,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [NIB_W-1:0] idx;
    logic             hit;
    logic             accept;

    enigma_code_lookup u_lookup (
        .code (code),
        .idx  (idx),
        .hit  (hit)
    );

    assign code_ready = !nib_valid || nib_ready;
    assign accept     = code_valid && code_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib       <= '0;
            nib_err   <= 1'b0;
            nib_valid <= 1'b0;
            rotor     <= ROTOR_INIT;
            err_count <= '0;
        end else begin
            if (accept) begin
                nib_valid <= 1'b1;
                if (hit) begin
                    nib     <= idx - rotor;
                    nib_err <= 1'b0;
                end else begin
                    nib     <= '0;
                    nib_err <= 1'b1;
                    if (err_count != '1)
                        err_count <= err_count + 1'b1;
                end
            end else if (nib_valid && nib_ready) begin
                nib_valid <= 1'b0;
            end

            // Decode above already used the pre-load rotor; a load overrides stepping.
            if (rotor_load)
                rotor <= rotor_val;
            else if (accept && hit)
                rotor <= rotor + ROTOR_STEP;
        end
    end

endmodule
